// File: rtl/adc_pkg.sv
// Shared ADC constants, output-format conversion and sampler FSM state encoding.
// Combinational helpers only; nothing here holds state or applies backpressure.
package adc_pkg;

    localparam logic [11:0] ADC_ZERO       = 12'h7FF;
    localparam int          ADC_FRAME_BITS = 16;
    localparam int          ADC_DATA_BITS  = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F1   = 3'd1,
        ST_GAP1 = 3'd2,
        ST_F2   = 3'd3,
        ST_DONE = 3'd4,
        ST_WAIT = 3'd5
    } state_t;

    // The ADC emits offset binary; downstream expects its bitwise inverse.
    function automatic logic [ADC_DATA_BITS-1:0] adc_fmt(input logic [ADC_DATA_BITS-1:0] raw);
        return raw ^ {ADC_DATA_BITS{1'b1}};
    endfunction

    function automatic logic [ADC_FRAME_BITS-1:0] adc_din_word(input logic [2:0] addr);
        return {2'b00, addr, 11'b0};
    endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// One 16-SCLK SPI frame per start pulse; done pulses on the clk cs_n rises, 32*CLK_DIV+2 clks after start.
// Starts arriving while a frame is running are ignored; no other backpressure.
module adc_spi_frame
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [2:0]  i_addr,
    output logic        o_done,
    output logic [11:0] o_data,
    output logic        o_cs_n,
    output logic        o_sclk,
    output logic        o_din,
    input  logic        i_dout
);

    localparam int         TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [5:0] LAST_HALF = 6'(2 * ADC_FRAME_BITS);

    logic [TW-1:0] r_tick;
    logic [5:0]    r_half;
    logic [15:0]   r_tx;
    logic [11:0]   r_rx;
    logic          r_cs_n;
    logic          r_sclk;
    logic          r_din;
    logic          r_done;
    logic          w_tick_end;

    assign w_tick_end = (r_tick == TW'(CLK_DIV - 1));

    // Half 0 is the cs_n-to-first-fall lead; odd halves are SCLK low, even halves SCLK high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
            r_half <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_cs_n <= 1'b1;
            r_sclk <= 1'b1;
            r_din  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_cs_n) begin
                if (i_start) begin
                    r_cs_n <= 1'b0;
                    r_tick <= '0;
                    r_half <= '0;
                    r_tx   <= adc_din_word(i_addr);
                end
            end else if (r_half == LAST_HALF) begin
                r_cs_n <= 1'b1;
                r_done <= 1'b1;
            end else if (w_tick_end) begin
                r_tick <= '0;
                r_half <= r_half + 6'd1;
                if (!r_half[0]) begin
                    r_sclk <= 1'b0;
                    r_din  <= r_tx[15];
                    r_tx   <= {r_tx[14:0], 1'b0};
                end else begin
                    r_sclk <= 1'b1;
                    r_rx   <= {r_rx[10:0], i_dout};
                end
            end else begin
                r_tick <= r_tick + TW'(1);
            end
        end
    end

    assign o_done = r_done;
    assign o_data = r_rx;
    assign o_cs_n = r_cs_n;
    assign o_sclk = r_sclk;
    assign o_din  = r_din;

endmodule

// File: rtl/adc_pair_sampler.sv
// Alternately converts igniter V and I over SPI, emitting a one-clk valid per pair every SAMPLE_PERIOD clks.
// No downstream backpressure: the consumer must take each pair on its valid pulse.
module adc_pair_sampler
    import adc_pkg::*;
#(
    parameter int         CLK_DIV       = 2,
    parameter int         SAMPLE_PERIOD = 192,
    parameter int         CS_GAP        = 2,
    parameter logic [2:0] V_CHAN        = 3'd0,
    parameter logic [2:0] I_CHAN        = 3'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic        valid_out,
    output logic [11:0] v_out,
    output logic [11:0] i_out
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_t      r_state;
    logic [PW-1:0] r_period;
    logic [GW-1:0] r_gap;
    logic        r_primed;
    logic        r_start;
    logic [2:0]  r_addr;
    logic [11:0] r_v_raw;
    logic        r_valid;
    logic [11:0] r_v_out;
    logic [11:0] r_i_out;

    logic        w_done;
    logic [11:0] w_data;
    logic        w_period_end;

    assign w_period_end = (r_period == PW'(SAMPLE_PERIOD - 1));

    adc_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk     (clk),
        .rst     (reset),
        .i_start (r_start),
        .i_addr  (r_addr),
        .o_done  (w_done),
        .o_data  (w_data),
        .o_cs_n  (adc_cs_n),
        .o_sclk  (adc_sclk),
        .o_din   (adc_din),
        .i_dout  (adc_dout)
    );

    // The ADC answers one frame late: F1 addresses I and returns V, F2 addresses V and returns I.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_period <= '0;
            r_gap    <= '0;
            r_primed <= 1'b0;
            r_start  <= 1'b0;
            r_addr   <= V_CHAN;
            r_v_raw  <= '0;
            r_valid  <= 1'b0;
            r_v_out  <= ADC_ZERO;
            r_i_out  <= ADC_ZERO;
        end else begin
            r_start <= 1'b0;
            r_valid <= 1'b0;
            if (r_state != ST_IDLE) begin
                r_period <= w_period_end ? '0 : r_period + PW'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state  <= ST_F1;
                        r_period <= '0;
                        r_start  <= 1'b1;
                        r_addr   <= I_CHAN;
                    end
                end
                ST_F1: begin
                    if (w_done) begin
                        r_v_raw <= w_data;
                        r_gap   <= '0;
                        r_state <= ST_GAP1;
                    end
                end
                ST_GAP1: begin
                    if (r_gap == GW'(CS_GAP - 1)) begin
                        r_state <= ST_F2;
                        r_start <= 1'b1;
                        r_addr  <= V_CHAN;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                ST_F2: begin
                    if (w_done) begin
                        r_state <= ST_DONE;
                        // Until one full pair has run, the ADC's leftover address is unknown.
                        if (r_primed) begin
                            r_valid <= 1'b1;
                            r_v_out <= adc_fmt(r_v_raw);
                            r_i_out <= adc_fmt(w_data);
                        end
                    end
                end
                ST_DONE: begin
                    r_primed <= 1'b1;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_period_end) begin
                        if (enable) begin
                            r_state <= ST_F1;
                            r_start <= 1'b1;
                            r_addr  <= I_CHAN;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign valid_out = r_valid;
    assign v_out     = r_v_out;
    assign i_out     = r_i_out;

endmodule
